// File: rtl/pe_pkg.sv
// pe_pkg: shared types and constants for the PE operand feeder.
//   feeder_state_t : feeder sequencer states
//   *_DEF          : default parameter values
//   TAP_W          : tap index width for the default kernel size
//   tap_width()    : tap index width for an arbitrary kernel size
package pe_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int KERNEL_SIZE_DEF = 9;
  localparam int WIN_CNT_W_DEF   = 16;
  localparam int TAP_W           = $clog2(KERNEL_SIZE_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } feeder_state_t;

  // Kernel sizes are at least 2, so $clog2 never collapses to zero here;
  // the floor of 1 just keeps vector declarations legal.
  function automatic int tap_width(input int k);
    return (k > 2) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/pe_operand_feeder_if.sv
// pe_operand_feeder_if: job control, filter/ifmap input streams and PE-side
// operand bus of the operand feeder, bundled in one interface.
//   master : the feeder (receives job/streams/PE status, drives operands)
//   slave  : the surrounding environment (host side and PE side)
interface pe_operand_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_CNT_W  = 16
);

  logic                  start;
  logic [WIN_CNT_W-1:0]  num_windows;
  logic [DATA_WIDTH-1:0] bias;
  logic                  fltr_in_valid;
  logic                  fltr_in_ready;
  logic [DATA_WIDTH-1:0] fltr_in_data;
  logic                  ifmap_in_valid;
  logic                  ifmap_in_ready;
  logic [DATA_WIDTH-1:0] ifmap_in_data;
  logic                  pe_ready;
  logic                  pe_valid;
  logic                  pe_en;
  logic [DATA_WIDTH-1:0] ifmap_data_M2P;
  logic [DATA_WIDTH-1:0] fltr_data_M2P;
  logic [DATA_WIDTH-1:0] psum_data_M2P;
  logic                  pe_first;
  logic                  pe_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, num_windows, bias,
    input  fltr_in_valid, fltr_in_data,
    input  ifmap_in_valid, ifmap_in_data,
    input  pe_ready, pe_valid,
    output fltr_in_ready, ifmap_in_ready,
    output pe_en, ifmap_data_M2P, fltr_data_M2P, psum_data_M2P,
    output pe_first, pe_last, busy, done
  );

  modport slave (
    output start, num_windows, bias,
    output fltr_in_valid, fltr_in_data,
    output ifmap_in_valid, ifmap_in_data,
    output pe_ready, pe_valid,
    input  fltr_in_ready, ifmap_in_ready,
    input  pe_en, ifmap_data_M2P, fltr_data_M2P, psum_data_M2P,
    input  pe_first, pe_last, busy, done
  );

endinterface

// File: rtl/pe_fltr_rf.sv
// pe_fltr_rf: DEPTH x DATA_WIDTH filter register file.
//   clk   : write clock
//   we    : write enable
//   waddr : write address (tap index)
//   wdata : write data
//   raddr : read address (tap index), asynchronous read
//   rdata : read data
// Contents are deliberately not reset; every job reloads all taps.
module pe_fltr_rf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 9,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] fltr_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) fltr_mem[waddr] <= wdata;
  end

  assign rdata = fltr_mem[raddr];

endmodule

// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: loads a KERNEL_SIZE-tap filter, then streams ifmap
// words to the PE paired with the stored weights, injecting the bias as
// the psum of tap 0. Finished windows are counted from pe_valid and a
// one-cycle done pulse closes the job.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : job control, filter/ifmap streams, PE operand bus (master)
module pe_operand_feeder
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int WIN_CNT_W   = WIN_CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  pe_operand_feeder_if.master bus
);

  localparam int                 TAP_BITS = tap_width(KERNEL_SIZE);
  localparam logic [TAP_BITS-1:0] LAST_TAP = TAP_BITS'(KERNEL_SIZE - 1);

  feeder_state_t         state_q,    state_d;
  logic [TAP_BITS-1:0]   ld_idx_q,   ld_idx_d;
  logic [TAP_BITS-1:0]   tap_q,      tap_d;
  logic [WIN_CNT_W-1:0]  win_sent_q, win_sent_d;
  logic [WIN_CNT_W-1:0]  win_done_q, win_done_d;
  logic [WIN_CNT_W-1:0]  num_win_q,  num_win_d;
  logic [DATA_WIDTH-1:0] bias_q,     bias_d;
  logic [DATA_WIDTH-1:0] ifmap_q,    ifmap_d;
  logic [DATA_WIDTH-1:0] fltr_q,     fltr_d;
  logic [DATA_WIDTH-1:0] psum_q,     psum_d;
  logic                  pe_en_q,    pe_en_d;
  logic                  first_q,    first_d;
  logic                  last_q,     last_d;
  logic                  done_q,     done_d;

  logic                  fltr_acc;
  logic                  ifmap_rdy;
  logic                  ifmap_acc;
  logic                  cnt_valid;
  logic [WIN_CNT_W-1:0]  win_done_inc;
  logic [WIN_CNT_W-1:0]  win_sent_inc;
  logic [DATA_WIDTH-1:0] tap_weight;

  assign fltr_acc  = (state_q == ST_LOAD) && bus.fltr_in_valid;
  assign ifmap_rdy = (state_q == ST_STREAM) && bus.pe_ready;
  assign ifmap_acc = ifmap_rdy && bus.ifmap_in_valid;

  // The incremented window-done count is used for both the register update
  // and the DRAIN exit test, so a pe_valid landing on the final ifmap accept
  // (or on the last DRAIN cycle) is never lost to the state change.
  assign cnt_valid    = bus.pe_valid && ((state_q == ST_STREAM) || (state_q == ST_DRAIN));
  assign win_done_inc = win_done_q + {{(WIN_CNT_W-1){1'b0}}, cnt_valid};
  assign win_sent_inc = win_sent_q + {{(WIN_CNT_W-1){1'b0}}, 1'b1};

  pe_fltr_rf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (KERNEL_SIZE),
    .ADDR_W     (TAP_BITS)
  ) u_fltr_rf (
    .clk   (clk),
    .we    (fltr_acc),
    .waddr (ld_idx_q),
    .wdata (bus.fltr_in_data),
    .raddr (tap_q),
    .rdata (tap_weight)
  );

  always_comb begin
    state_d    = state_q;
    ld_idx_d   = ld_idx_q;
    tap_d      = tap_q;
    win_sent_d = win_sent_q;
    win_done_d = win_done_inc;
    num_win_d  = num_win_q;
    bias_d     = bias_q;
    ifmap_d    = ifmap_q;
    fltr_d     = fltr_q;
    psum_d     = psum_q;
    first_d    = first_q;
    last_d     = last_q;
    pe_en_d    = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.num_windows == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ST_LOAD;
            num_win_d = bus.num_windows;
            bias_d    = bus.bias;
            ld_idx_d  = '0;
          end
        end
      end

      ST_LOAD: begin
        if (fltr_acc) begin
          if (ld_idx_q == LAST_TAP) begin
            ld_idx_d = '0;
            tap_d    = '0;
            state_d  = ST_STREAM;
          end else begin
            ld_idx_d = ld_idx_q + 1'b1;
          end
        end
      end

      ST_STREAM: begin
        if (ifmap_acc) begin
          pe_en_d = 1'b1;
          ifmap_d = bus.ifmap_in_data;
          fltr_d  = tap_weight;
          psum_d  = (tap_q == '0) ? bias_q : '0;
          first_d = (tap_q == '0);
          last_d  = (tap_q == LAST_TAP);
          if (tap_q == LAST_TAP) begin
            tap_d      = '0;
            win_sent_d = win_sent_inc;
            if (win_sent_inc == num_win_q) state_d = ST_DRAIN;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (win_done_inc == num_win_q) begin
          done_d     = 1'b1;
          state_d    = ST_IDLE;
          tap_d      = '0;
          win_sent_d = '0;
          win_done_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      ld_idx_q   <= '0;
      tap_q      <= '0;
      win_sent_q <= '0;
      win_done_q <= '0;
      num_win_q  <= '0;
      bias_q     <= '0;
      ifmap_q    <= '0;
      fltr_q     <= '0;
      psum_q     <= '0;
      pe_en_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_idx_q   <= ld_idx_d;
      tap_q      <= tap_d;
      win_sent_q <= win_sent_d;
      win_done_q <= win_done_d;
      num_win_q  <= num_win_d;
      bias_q     <= bias_d;
      ifmap_q    <= ifmap_d;
      fltr_q     <= fltr_d;
      psum_q     <= psum_d;
      pe_en_q    <= pe_en_d;
      first_q    <= first_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign bus.fltr_in_ready  = (state_q == ST_LOAD);
  assign bus.ifmap_in_ready = ifmap_rdy;
  assign bus.pe_en          = pe_en_q;
  assign bus.ifmap_data_M2P = ifmap_q;
  assign bus.fltr_data_M2P  = fltr_q;
  assign bus.psum_data_M2P  = psum_q;
  assign bus.pe_first       = first_q;
  assign bus.pe_last        = last_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = done_q;

endmodule

// File: tb/tb_pe_operand_feeder.sv
module tb_pe_operand_feeder;

  localparam int DW = 16;
  localparam int K  = 9;
  localparam int WW = 16;

  logic clk = 1'b0;
  logic rstn;

  pe_operand_feeder_if #(.DATA_WIDTH(DW), .WIN_CNT_W(WW)) bus ();

  pe_operand_feeder #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (K),
    .WIN_CNT_W   (WW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] ifm;
    logic [DW-1:0] flt;
    logic [DW-1:0] ps;
    logic          first;
    logic          last;
  } op_t;

  op_t           sb_q [$];
  op_t           mon_e;
  int            n_chk  = 0;
  int            n_err  = 0;
  int            en_cnt = 0;
  logic [DW-1:0] filt [K];
  logic [DW-1:0] bias_m;
  logic          bp_mode = 1'b0;
  logic          bp_ph   = 1'b1;
  int            bp_cnt  = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pe_ready: steady high, or 2 cycles high / 2 cycles low in back-pressure mode
  initial begin
    bus.pe_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        bp_cnt++;
        if (bp_cnt % 2 == 0) bp_ph = ~bp_ph;
        bus.pe_ready = bp_ph;
      end else begin
        bus.pe_ready = 1'b1;
      end
    end
  end

  // Operand monitor: every pe_en strobe is matched against the scoreboard
  always @(negedge clk) begin
    if (rstn && bus.pe_en) begin
      en_cnt++;
      if (sb_q.size() == 0) begin
        chk_val("sb_underflow", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk_val("op_ifmap", 64'(bus.ifmap_data_M2P), 64'(mon_e.ifm));
        chk_val("op_fltr",  64'(bus.fltr_data_M2P),  64'(mon_e.flt));
        chk_val("op_psum",  64'(bus.psum_data_M2P),  64'(mon_e.ps));
        chk_val("op_first", 64'(bus.pe_first),       64'(mon_e.first));
        chk_val("op_last",  64'(bus.pe_last),        64'(mon_e.last));
      end
    end
    if (rstn && bp_mode && !bus.pe_ready)
      chk_val("ifmap_rdy_stalled", 64'(bus.ifmap_in_ready), 64'd0);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_job(input logic [WW-1:0] nw, input logic [DW-1:0] b);
    bus.start       = 1'b1;
    bus.num_windows = nw;
    bus.bias        = b;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic load_filter(input int busy_at);
    bit acc;
    int guard;
    for (int i = 0; i < K; i++) begin
      acc   = 1'b0;
      guard = 0;
      bus.fltr_in_valid = 1'b1;
      bus.fltr_in_data  = filt[i];
      if (i == busy_at) begin
        bus.start       = 1'b1;
        bus.num_windows = 16'd3;
      end
      while (!acc && guard < 100) begin
        @(negedge clk);
        acc = bus.fltr_in_ready;
        @(posedge clk); #1;
        bus.start = 1'b0;
        guard++;
      end
      if (!acc) chk_val("fltr_load_timeout", 64'd0, 64'd1);
    end
    bus.fltr_in_valid = 1'b0;
  endtask

  // Streams nwin windows; stops before word stop_at; raises pe_valid with word pv_at.
  // cval >= 0 gives a constant ifmap value, otherwise a per-word pattern.
  task automatic stream(input int nwin, input int stop_at, input int pv_at, input int cval);
    bit  acc;
    int  guard;
    int  idx;
    op_t e;
    for (int w = 0; w < nwin; w++) begin
      for (int t = 0; t < K; t++) begin
        idx = w * K + t;
        if (idx == stop_at) begin
          bus.ifmap_in_valid = 1'b0;
          return;
        end
        bus.ifmap_in_valid = 1'b1;
        bus.ifmap_in_data  = (cval >= 0) ? DW'(cval) : DW'(16'h100 + idx * 5);
        bus.pe_valid       = (idx == pv_at);
        e.ifm   = bus.ifmap_in_data;
        e.flt   = filt[t];
        e.ps    = (t == 0) ? bias_m : '0;
        e.first = (t == 0);
        e.last  = (t == K - 1);
        sb_q.push_back(e);
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
          @(negedge clk);
          acc = bus.ifmap_in_ready;
          @(posedge clk); #1;
          bus.pe_valid = 1'b0;
          guard++;
        end
        if (!acc) chk_val("ifmap_timeout", 64'd0, 64'd1);
        else      chk_val("en_after_accept", 64'(bus.pe_en), 64'd1);
      end
    end
    bus.ifmap_in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [DW-1:0] b, input int busy_at, input int cval, input string tg);
    en_cnt = 0;
    bias_m = b;
    start_job(16'd1, b);
    load_filter(busy_at);
    stream(1, -1, -1, cval);
    chk_val({tg, "_drain_busy"}, 64'(bus.busy), 64'd1);
    chk_val({tg, "_drain_done"}, 64'(bus.done), 64'd0);
    bus.pe_valid = 1'b1;
    cyc(1);
    bus.pe_valid = 1'b0;
    chk_val({tg, "_done"},   64'(bus.done), 64'd1);
    chk_val({tg, "_idle"},   64'(bus.busy), 64'd0);
    chk_val({tg, "_en_cnt"}, 64'(en_cnt), 64'd9);
    chk_val({tg, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    cyc(1);
    chk_val({tg, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tg);
    chk_val({tg, "_pe_en"},     64'(bus.pe_en), 64'd0);
    chk_val({tg, "_first"},     64'(bus.pe_first), 64'd0);
    chk_val({tg, "_last"},      64'(bus.pe_last), 64'd0);
    chk_val({tg, "_done"},      64'(bus.done), 64'd0);
    chk_val({tg, "_busy"},      64'(bus.busy), 64'd0);
    chk_val({tg, "_fltr_rdy"},  64'(bus.fltr_in_ready), 64'd0);
    chk_val({tg, "_ifmap_rdy"}, 64'(bus.ifmap_in_ready), 64'd0);
    chk_val({tg, "_ifmap_op"},  64'(bus.ifmap_data_M2P), 64'd0);
    chk_val({tg, "_fltr_op"},   64'(bus.fltr_data_M2P), 64'd0);
    chk_val({tg, "_psum_op"},   64'(bus.psum_data_M2P), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start          = 1'b0;
    bus.num_windows    = '0;
    bus.bias           = '0;
    bus.fltr_in_valid  = 1'b0;
    bus.fltr_in_data   = '0;
    bus.ifmap_in_valid = 1'b0;
    bus.ifmap_in_data  = '0;
    bus.pe_valid       = 1'b0;
    rstn               = 1'b0;
    cyc(2);
    chk_reset_outputs("rst");
    rstn = 1'b1;
    cyc(1);

    // Load and single window: filter 1..9, ifmap all 2, bias 3
    for (int i = 0; i < K; i++) filt[i] = DW'(i + 1);
    run_one(16'd3, -1, 2, "t1");

    // Back-pressure: two windows with pe_ready toggling every 2 cycles
    en_cnt  = 0;
    bias_m  = 16'd5;
    bp_mode = 1'b1;
    start_job(16'd2, 16'd5);
    load_filter(-1);
    stream(2, -1, -1, -1);
    bp_mode = 1'b0;
    cyc(2);
    chk_val("bp_en_cnt", 64'(en_cnt), 64'd18);
    chk_val("bp_sb_empty", 64'(sb_q.size()), 64'd0);
    bus.pe_valid = 1'b1;
    cyc(1);
    chk_val("bp_done_early", 64'(bus.done), 64'd0);
    cyc(1);
    bus.pe_valid = 1'b0;
    chk_val("bp_done", 64'(bus.done), 64'd1);
    cyc(1);

    // Zero windows: done one cycle later, never busy, never loading
    start_job(16'd0, 16'd7);
    chk_val("zw_done", 64'(bus.done), 64'd1);
    chk_val("zw_busy", 64'(bus.busy), 64'd0);
    chk_val("zw_fltr_rdy", 64'(bus.fltr_in_ready), 64'd0);
    cyc(1);
    chk_val("zw_done_pulse", 64'(bus.done), 64'd0);
    chk_val("zw_busy2", 64'(bus.busy), 64'd0);
    chk_val("zw_fltr_rdy2", 64'(bus.fltr_in_ready), 64'd0);

    // Simultaneous: pe_valid for window 0 on the final ifmap accept
    for (int i = 0; i < K; i++) filt[i] = DW'(10 + 3 * i);
    en_cnt = 0;
    bias_m = 16'h21;
    start_job(16'd2, 16'h21);
    load_filter(-1);
    stream(2, -1, 2 * K - 1, -1);
    cyc(2);
    chk_val("sim_busy", 64'(bus.busy), 64'd1);
    chk_val("sim_no_done", 64'(bus.done), 64'd0);
    chk_val("sim_en_cnt", 64'(en_cnt), 64'd18);
    bus.pe_valid = 1'b1;
    cyc(1);
    bus.pe_valid = 1'b0;
    chk_val("sim_done", 64'(bus.done), 64'd1);
    cyc(1);

    // Reset mid-stream at tap 4 of window 0
    for (int i = 0; i < K; i++) filt[i] = DW'(7 * i + 1);
    bias_m = 16'd9;
    start_job(16'd1, 16'd9);
    load_filter(-1);
    stream(1, 4, -1, -1);
    @(negedge clk); #2;
    bus.ifmap_in_valid = 1'b1;
    bus.ifmap_in_data  = 16'hbeef;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    chk_val("mid_rst_sb_empty", 64'(sb_q.size()), 64'd0);
    bus.ifmap_in_valid = 1'b0;
    @(posedge clk); #1;
    cyc(1);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk_val("mid_rst_no_done", 64'(bus.done), 64'd0);
    end
    for (int i = 0; i < K; i++) filt[i] = DW'(20 + i);
    run_one(16'd4, -1, -1, "post_rst");

    // start while busy: second start during LOAD must not change the count
    for (int i = 0; i < K; i++) filt[i] = DW'(16'h40 - i);
    run_one(16'd6, 3, -1, "busy_start");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
